// File: rtl/ofdm_fec_pkg.sv
// Shared definitions for the OFDM FEC encoder peripheral: register map,
// CSR bit positions, default code generators / scrambler seed, FSM encoding
// and a small parity helper used by the convolutional encoder core.
package ofdm_fec_pkg;

    // Register addresses within the peripheral
    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_DATA   = 4'h2;
    localparam logic [3:0] ADDR_SEED   = 4'h3;
    localparam logic [3:0] ADDR_OUT_LO = 4'h4;
    localparam logic [3:0] ADDR_OUT_HI = 4'h5;
    localparam logic [3:0] ADDR_SCRDBG = 4'h6;

    // CTRL bit positions
    localparam int CTRL_SCRAM_EN = 0;
    localparam int CTRL_CLEAR    = 3;

    // STATUS bit positions (also the acknowledge bits on a STATUS write)
    localparam int STAT_BUSY      = 0;
    localparam int STAT_OUT_VALID = 1;
    localparam int STAT_OVERRUN   = 2;

    // Default generators (802.11 K=7, rate 1/2) and scrambler seed
    localparam logic [6:0] G0_DEF            = 7'o133;
    localparam logic [6:0] G1_DEF            = 7'o171;
    localparam logic [6:0] SCRAM_SEED_RST_DEF = 7'h7F;

    // Controller states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fec_state_e;

    // Even parity of the generator-masked encoder window
    function automatic logic parity7(input logic [6:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ofdm_fec_encoder_conv_enc_k7.sv
// Bit-serial K=7 rate-1/2 convolutional encoder core.
// Window bit 6 is the current input u, bit 5 is d1 ... bit 0 is d6, so a
// generator written in octal (MSB = current bit) masks the window directly.
// A and B are combinational functions of u and the delay line; the delay
// line advances only when en is high, and clr empties it (clr wins over en).
module ofdm_conv_enc_k7
    import ofdm_fec_pkg::*;
#(
    parameter logic [6:0] G0 = G0_DEF,
    parameter logic [6:0] G1 = G1_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic u,
    output logic A,
    output logic B
);

    // r_dly[0] = d1 (most recent), r_dly[5] = d6 (oldest)
    logic [5:0] r_dly;
    logic [6:0] w_win;

    assign w_win = {u, r_dly[0], r_dly[1], r_dly[2], r_dly[3], r_dly[4], r_dly[5]};
    assign A     = parity7(w_win & G0);
    assign B     = parity7(w_win & G1);

    // Delay line: cleared by clr, shifts in u on each enabled bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= 6'b000000;
        end else if (clr) begin
            r_dly <= 6'b000000;
        end else if (en) begin
            r_dly <= {r_dly[4:0], u};
        end else begin
            r_dly <= r_dly;
        end
    end

endmodule

// File: rtl/ofdm_fec_encoder.sv
// TinyQV peripheral: per-byte 802.11 scrambler (x^7+x^4+1) followed by a
// K=7 rate-1/2 convolutional encoder, one bit per clock, LSB first.
// The 16 coded bits of each byte are exposed as OUT_LO / OUT_HI.
// Optional build macro OFDM_FEC_SCRAMBLED_READBACK_EN adds a read-only view
// (address 0x6) of the scrambled byte from the last completed run.
module ofdm_fec_encoder
    import ofdm_fec_pkg::*;
#(
    parameter logic [6:0] SCRAM_SEED_RST = SCRAM_SEED_RST_DEF,
    parameter logic [6:0] G0             = G0_DEF,
    parameter logic [6:0] G1             = G1_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    fec_state_e r_state;
    fec_state_e w_state_nxt;

    logic [7:0]  r_ctrl;
    logic        r_out_valid;
    logic        r_overrun;
    logic [7:0]  r_data;
    logic [7:0]  r_byte;
    logic [6:0]  r_seed;
    logic [6:0]  r_scr;
    logic [2:0]  r_bit_cnt;
    logic [15:0] r_acc;
    logic [15:0] r_out;

    logic w_wr_ctrl, w_wr_stat, w_wr_data, w_wr_seed;
    logic w_clear, w_running, w_step, w_done, w_accept;
    logic w_scram_en, w_d, w_fb, w_u, w_a, w_b;
    logic [15:0] w_coded;
    logic w_unused;

    assign uo_out   = 8'h00;
    assign w_unused = &{1'b0, ui_in};

    // Bus write decode
    assign w_wr_ctrl = data_write && (address == ADDR_CTRL);
    assign w_wr_stat = data_write && (address == ADDR_STATUS);
    assign w_wr_data = data_write && (address == ADDR_DATA);
    assign w_wr_seed = data_write && (address == ADDR_SEED);
    assign w_clear   = w_wr_ctrl && data_in[CTRL_CLEAR];

    // Run control: a clear aborts the run and beats a same-cycle completion
    assign w_running = (r_state == ST_RUN);
    assign w_step    = w_running && !w_clear;
    assign w_done    = w_step && (r_bit_cnt == 3'd7);
    assign w_accept  = w_wr_data && !w_running;

    // Scrambler and encoder input for the current bit
    assign w_scram_en = r_ctrl[CTRL_SCRAM_EN];
    assign w_d        = r_byte[r_bit_cnt];
    assign w_fb       = r_scr[6] ^ r_scr[3];
    assign w_u        = w_scram_en ? (w_d ^ w_fb) : w_d;
    assign w_coded    = {w_b, w_a, r_acc[15:2]};

    ofdm_conv_enc_k7 #(
        .G0 (G0),
        .G1 (G1)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clear),
        .en    (w_step),
        .u     (w_u),
        .A     (w_a),
        .B     (w_b)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: start on a DATA write, stop after bit 7 or on clear
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_data) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_clear || (r_bit_cnt == 3'd7)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Software-visible configuration registers (CTRL, SEED, DATA readback)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= 8'h00;
            r_seed <= SCRAM_SEED_RST;
            r_data <= 8'h00;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= data_in & 8'hF7;
            end
            if (w_wr_seed) begin
                r_seed <= data_in[6:0];
            end
            if (w_accept) begin
                r_data <= data_in;
            end
        end
    end

    // Status flags: completion beats an ack; a rejected or unread byte flags overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_done) begin
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end else if (w_wr_stat && data_in[STAT_OUT_VALID]) begin
                r_out_valid <= 1'b0;
            end
            if (w_wr_data && (w_running || r_out_valid)) begin
                r_overrun <= 1'b1;
            end else if (w_wr_stat && data_in[STAT_OVERRUN]) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Run datapath: byte latch, bit counter, scrambler, coded-bit collection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte    <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_scr     <= SCRAM_SEED_RST;
            r_acc     <= 16'h0000;
            r_out     <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_byte    <= data_in;
                r_bit_cnt <= 3'd0;
            end else if (w_step) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_clear) begin
                r_scr <= r_seed;
            end else if (w_step && w_scram_en) begin
                r_scr <= {r_scr[5:0], w_fb};
            end
            if (w_step) begin
                r_acc <= w_coded;
            end
            if (w_done) begin
                r_out <= w_coded;
            end
        end
    end

`ifdef OFDM_FEC_SCRAMBLED_READBACK_EN
    logic [7:0] r_u_acc;
    logic [7:0] r_scr_dbg;

    // Collect scrambled bits of the run and publish them on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_u_acc   <= 8'h00;
            r_scr_dbg <= 8'h00;
        end else begin
            if (w_step) begin
                r_u_acc <= {w_u, r_u_acc[7:1]};
            end
            if (w_done) begin
                r_scr_dbg <= {w_u, r_u_acc[7:1]};
            end
        end
    end
`endif

    // Combinational register read mux
    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_CTRL:   data_out = r_ctrl;
            ADDR_STATUS: data_out = {5'b00000, r_overrun, r_out_valid, w_running};
            ADDR_DATA:   data_out = r_data;
            ADDR_SEED:   data_out = {1'b0, r_seed};
            ADDR_OUT_LO: data_out = r_out[7:0];
            ADDR_OUT_HI: data_out = r_out[15:8];
`ifdef OFDM_FEC_SCRAMBLED_READBACK_EN
            ADDR_SCRDBG: data_out = r_scr_dbg;
`else
            ADDR_SCRDBG: data_out = 8'h00;
`endif
            default:     data_out = 8'h00;
        endcase
    end

endmodule

// File: doc/ofdm_fec_encoder.md
Name: ofdm_fec_encoder

Overview:
TinyQV peripheral that sits directly upstream of the OFDM symbol mapper. Software writes payload bytes one at a time. Each byte is optionally scrambled with the 802.11 scrambler (x^7+x^4+1), then convolutionally encoded (K=7, rate 1/2, generators 133/171 octal), one bit per clock. The resulting 16 coded bits are presented as two readable bytes; software feeds them to the mapper's data register.

Parameters:
- SCRAM_SEED_RST, 7'h7F, reset value of the SEED register.
- G0, 7'o133, generator for coded bit A.
- G1, 7'o171, generator for coded bit B.

Ports:
- clk  in  1  project clock (64 MHz nominal)
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- ui_in  in  8  input PMOD; unused
- uo_out  out  8  output PMOD; driven constant 8'h00
- address  in  4  register address within the peripheral
- data_write  in  1  write strobe from the TinyQV core
- data_in  in  8  write data, valid with data_write
- data_out  out  8  combinational read data for address

Behaviour:
- Register map:
  - 0x0 CTRL (RW): bit0 scram_en; bit3 clear (write-1 strobe, reads 0); other bits read back as written.
  - 0x1 STATUS (RO): bit0 busy, bit1 out_valid, bit2 overrun (sticky). A write to 0x1 acknowledges: data_in bit1=1 clears out_valid, bit2=1 clears overrun.
  - 0x2 DATA (RW): a write launches encoding; a read returns the last written byte.
  - 0x3 SEED (RW, 7 bits): scrambler seed; bit7 reads 0.
  - 0x4 OUT_LO: coded bits c[7:0].
  - 0x5 OUT_HI: coded bits c[15:8].
  - Any other address reads 8'h00.
- Reset values:
  - All registers 0, except SEED = SCRAM_SEED_RST and scrambler state = SCRAM_SEED_RST.
  - FSM in IDLE; uo_out = 0.
- FSM states: IDLE and RUN.
  - IDLE -> RUN on a write to DATA. The byte is latched, bit counter = 0, busy = 1 on the next cycle.
  - RUN processes one input bit per cycle, LSB first, for exactly 8 cycles.
  - After the edge that processes bit 7: OUT_LO/OUT_HI update, out_valid = 1, busy = 0, state returns to IDLE.
  - Latency: DATA write edge to out_valid visible = 9 clocks.
- Scrambler, per bit when scram_en=1:
  - fb = x[6]^x[3]; u = d ^ fb; x <= {x[5:0], fb}.
  - When scram_en=0: u = d and x holds its value.
- Encoder, per bit:
  - Delays d1..d6 are the previous u values.
  - A = u^d2^d3^d5^d6; B = u^d1^d2^d3^d6.
  - For input bit k: c[2k] = A, c[2k+1] = B.
- Encoder and scrambler state persist across bytes (continuous stream).
- clear strobe:
  - Encoder delays = 0; scrambler state = SEED.
  - If RUN, the byte is aborted: state IDLE, busy = 0, out_valid unchanged, outputs not updated.
  - clear takes priority over a same-cycle completion.
- Boundary conditions:
  - DATA write while busy: byte ignored, overrun = 1, run continues unaffected. This includes the completion edge.
  - DATA write in IDLE with out_valid=1: accepted, overrun = 1, out_valid = 0.
  - Completion and STATUS ack in the same cycle: out_valid ends at 1 (completion wins).
  - SEED write does not affect the live scrambler until clear.
  - Reset mid-run: everything returns to reset values immediately.

Optional Feature:
- Macro: OFDM_FEC_SCRAMBLED_READBACK_EN.
- Defined: address 0x6 returns the scrambled byte (u bits 7..0) of the last completed run, reset 0.
- Undefined: no storage is built and address 0x6 reads 8'h00.

Decomposition:
- Package ofdm_fec_pkg:
  - Register address localparams (CTRL/STATUS/DATA/SEED/OUT_LO/OUT_HI/SCRDBG).
  - STATUS/CTRL bit indices.
  - Default generators and seed.
  - FSM state encoding.
- Sub-module ofdm_conv_enc_k7: bit-serial encoder core.
  - Ports: clk, rst_n, clr, en, u, A, B.
  - Holds d1..d6.
- Top level keeps the CSRs, scrambler and FSM.

Test Plan:
1. Reset, then read all addresses -> STATUS=0x00, SEED=0x7F, OUT_LO/OUT_HI=0x00, uo_out=0x00.
2. scram_en=0, clear, write DATA=0x01 -> busy for 8 cycles, out_valid on the 9th edge, OUT_LO=0xFB, OUT_HI=0x34.
3. clear, write 0x80 -> OUT_LO=0x00, OUT_HI=0xC0. Ack, then write 0x00 -> OUT_LO=0x3E, OUT_HI=0x0D (state persistence).
4. scram_en=1, SEED=0x7F, clear, write 0x00 -> OUT_LO=0x00, OUT_HI=0xA7. With the macro defined, 0x6 reads 0x70.
5. Write DATA at cycle 3 of a run -> overrun=1, result still that of the first byte. Write 0x04 to STATUS -> overrun=0.
6. clear at cycle 4 of a run -> busy=0, out_valid stays 0, OUT regs unchanged. Rerun of 0x01 -> 0xFB/0x34. Asserting rst_n low mid-run returns all registers to reset values.
